uart_receiver: RTL



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_receiver.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM encodings, data width, default oversample rate.
// Parity helper is used only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_BITS     = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        START     = 3'b001,
        DATA      = 3'b010,
        PARITY    = 3'b011,
        STOP      = 3'b100,
        WAIT_HIGH = 3'b101
    } rx_state_e;

    // Even parity: a clean frame XORs to zero across data and parity bit.
    function automatic logic even_parity_err(input logic [UART_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rx_in synchronizer (flops reset high = idle line) with registered falling-edge strobe.
// Latency: rx_sync follows rx_in after SYNC_STAGES cycles; rx_fall pulses in that same cycle.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic rx_in,
    output logic rx_sync,
    output logic rx_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   fall_q;

    // The edge is flagged from the next value of the last stage, so the strobe
    // lines up with rx_sync going low instead of trailing it by a cycle.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
            fall_q <= sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];
        end
    end

    assign rx_sync = sync_q[SYNC_STAGES-1];
    assign rx_fall = fall_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver (8E1 with UART_RX_PARITY_EN): 16x oversampled, mid-bit sampling, pulsed status.
// Results registered one cycle after the stop-bit sample tick; no backpressure, byte held until next good frame.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic                      tick16,
    input  logic                      rx_in,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_valid,
    output logic                      frame_err,
    output logic                      parity_err
);

    localparam int             TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  MID_START = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  MID_BIT   = TW'(OVERSAMPLE - 1);

    logic rx_sync;
    logic rx_fall;

    rx_state_e                 state_q, state_d;
    logic [TW-1:0]             tcnt_q,  tcnt_d;
    logic [2:0]                bcnt_q,  bcnt_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q,  data_d;
    logic                      dv_q,    dv_d;
    logic                      fe_q,    fe_d;
`ifdef UART_RX_PARITY_EN
    logic                      par_q,   par_d;
    logic                      pe_q,    pe_d;
`endif

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in  (clk_in),
        .reset   (reset),
        .rx_in   (rx_in),
        .rx_sync (rx_sync),
        .rx_fall (rx_fall)
    );

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        pe_d    = 1'b0;
`endif
        if (tick16) begin
            tcnt_d = tcnt_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (rx_fall) begin
                    state_d = START;
                end
            end

            START: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (tick16 && tcnt_q == MID_START) begin
                    tcnt_d = '0;
                    if (rx_sync) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bcnt_d  = '0;
                    end
                end
            end

            DATA: begin
                if (tick16 && tcnt_q == MID_BIT) begin
                    shift_d = {rx_sync, shift_q[UART_DATA_BITS-1:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        tcnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick16 && tcnt_q == MID_BIT) begin
                    par_d   = rx_sync;
                    tcnt_d  = '0;
                    state_d = STOP;
                end
            end
`endif

            STOP: begin
                if (tick16 && tcnt_q == MID_BIT) begin
                    tcnt_d = '0;
                    if (rx_sync) begin
                        data_d  = shift_q;
                        dv_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
                        pe_d    = even_parity_err(shift_q, par_q);
`endif
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end

            WAIT_HIGH: begin
                // Hold off through a break so a long low never looks like a start bit.
                tcnt_d = '0;
                if (rx_sync) begin
                    state_d = IDLE;
                end
            end

            default: begin
                tcnt_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            pe_q    <= pe_d;
`endif
        end
    end

    assign data_out   = data_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
